// File: rtl/if_fetch_queue.sv
// if_fetch_queue: multi-outstanding instruction fetch with a decoupling FIFO toward decode.
// Optional build macro FETCH_PERF_EN adds perf_fetch_cnt / perf_discard_cnt outputs.
// Contains the generic queue if_fq_fifo used for both the pc queue and the instruction FIFO.

// Generic circular queue with single-cycle flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is ignored when full unless a pop frees the slot in the same cycle.
module if_fq_fifo #(
  parameter int W = 32,
  parameter int D = 4,
  localparam int AW = (D > 1) ? $clog2(D) : 1,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic          head_vld,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign do_pop   = pop_rdy & head_vld;
  assign do_push  = push_vld & ((count != CW'(D)) | do_pop);

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; left unreset since entries are only observable through head_vld.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

// Fetch queue: issues in-order SRAM reads, tracks their pcs, buffers returns toward decode.
// Latency: 1 cycle from inst_sram_data_ok to fs2ds_valid (registered FIFO, no rdata bypass).
// Backpressure: requests are only issued while every in-flight return is guaranteed a FIFO slot.
module if_fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1C00_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        ds_allowin,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_entry,
  output logic        fs2ds_valid,
  output logic [64:0] fs2ds_bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic          redirect;
  logic [31:0]   redir_pc;
  logic          pend_vld;
  logic [31:0]   pend_pc;
  logic [31:0]   seq_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_cnt;
  logic [CW-1:0] fq_count;
  logic          pcq_vld;
  logic [31:0]   pcq_pc;
  logic          accept;
  logic          ret;
  logic          drop;
  logic          push;
  logic          fq_vld;
  logic [64:0]   fq_head;
  logic [64:0]   fq_push_dat;

  // Redirect arbitration: exception beats ertn, ertn beats branch.
  always_comb begin
    redirect = wb_ex | ertn_flush | br_taken;
    redir_pc = br_target;
    if (wb_ex)           redir_pc = ex_entry;
    else if (ertn_flush) redir_pc = ertn_entry;
  end

  // Fetch address: live redirect, then a redirect still waiting for acceptance, then sequential.
  always_comb begin
    if (redirect)      inst_sram_addr = redir_pc;
    else if (pend_vld) inst_sram_addr = pend_pc;
    else               inst_sram_addr = seq_pc;
  end

  // Outstanding plus buffered never exceeds DEPTH, so a return always finds a slot.
  assign inst_sram_req = resetn & ~br_stall
                       & (32'(outstanding) < MAX_OUTSTANDING)
                       & ((32'(outstanding) + 32'(fq_count)) < DEPTH);

  assign accept      = inst_sram_req & inst_sram_addr_ok;
  // A data_ok with nothing in flight is meaningless and leaves all state untouched.
  assign ret         = inst_sram_data_ok & pcq_vld;
  // Returns in a redirect cycle or while stale responses remain are thrown away.
  assign drop        = ret & (redirect | (discard_cnt != '0));
  assign push        = ret & ~drop;
  assign fq_push_dat = {(pcq_pc[1:0] != 2'b00), inst_sram_rdata, pcq_pc};

  // Pcs of accepted requests in issue order; its occupancy is the outstanding count.
  if_fq_fifo #(.W(32), .D(MAX_OUTSTANDING)) u_pcq (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (1'b0),
    .push_vld (accept),
    .push_dat (inst_sram_addr),
    .pop_rdy  (ret),
    .head_vld (pcq_vld),
    .head_dat (pcq_pc),
    .count    (outstanding)
  );

  // Instruction buffer toward decode; a redirect empties it.
  if_fq_fifo #(.W(65), .D(DEPTH)) u_fq (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (redirect),
    .push_vld (push),
    .push_dat (fq_push_dat),
    .pop_rdy  (ds_allowin),
    .head_vld (fq_vld),
    .head_dat (fq_head),
    .count    (fq_count)
  );

  assign fs2ds_valid = fq_vld;
  assign fs2ds_bus   = fq_vld ? fq_head : '0;

  // Sequential pc follows the last accepted address; a redirect is parked until accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seq_pc   <= RESET_PC;
      pend_vld <= 1'b0;
      pend_pc  <= RESET_PC;
    end else begin
      if (accept) seq_pc <= inst_sram_addr + 32'd4;
      if (redirect && !accept) begin
        pend_vld <= 1'b1;
        pend_pc  <= redir_pc;
      end else if (accept) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Stale-response counter: a redirect marks everything still in flight (minus this cycle's return) stale.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard_cnt <= '0;
    end else if (redirect) begin
      discard_cnt <= outstanding - OW'(ret);
    end else if (drop) begin
      discard_cnt <= discard_cnt - 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  // Free-running event counters for accepted fetches and dropped returns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_cnt   <= '0;
      perf_discard_cnt <= '0;
    end else begin
      perf_fetch_cnt   <= perf_fetch_cnt + 32'(accept);
      perf_discard_cnt <= perf_discard_cnt + 32'(drop);
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: fixed vector table, directed corner sequences, then random traffic
// checked every cycle against a queue-based model of the fetch/return/redirect rules.
module tb_if_fetch_queue;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] B     = 32'h1C00_0000;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        wb_ex;
  logic [31:0] ex_entry;
  logic        ertn_flush;
  logic [31:0] ertn_entry;
  logic        fs2ds_valid;
  logic [64:0] fs2ds_bus;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_discard_cnt;
`endif

  if_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(B)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .ds_allowin        (ds_allowin),
    .br_stall          (br_stall),
    .br_taken          (br_taken),
    .br_target         (br_target),
    .wb_ex             (wb_ex),
    .ex_entry          (ex_entry),
    .ertn_flush        (ertn_flush),
    .ertn_entry        (ertn_entry),
    .fs2ds_valid       (fs2ds_valid),
    .fs2ds_bus         (fs2ds_bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_discard_cnt  (perf_discard_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        br_stall;
    logic        addr_ok;
    logic        data_ok;
    logic        allowin;
    logic        br_taken;
    logic        wb_ex;
    logic        ertn;
    logic [31:0] br_target;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: pcs in flight, buffered entries, stale count, pending redirect, next pc.
  logic [31:0] q_pc[$];
  logic [64:0] q_fq[$];
  int          m_disc = 0;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = '0;
  logic [31:0] m_seq = B;
  logic [31:0] m_pf = '0;
  logic [31:0] m_pd = '0;

  // Last sampled DUT outputs.
  logic        s_req;
  logic        s_vld;
  logic [31:0] s_addr;
  logic [64:0] s_bus;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(bit aok, bit dok, bit alw);
    stim_t s;
    s = '0;
    s.addr_ok = aok;
    s.data_ok = dok;
    s.allowin = alw;
    s.rdata   = $urandom;
    return s;
  endfunction

  function automatic vec_t v(bit aok, bit dok, bit alw, bit br, logic [31:0] tgt,
                             bit req, logic [31:0] addr, bit vld, logic [31:0] pc);
    vec_t r;
    r.s           = mk(aok, dok, alw);
    r.s.br_taken  = br;
    r.s.br_target = tgt;
    r.req         = req;
    r.addr        = addr;
    r.vld         = vld;
    r.pc          = pc;
    return r;
  endfunction

  // One cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input stim_t s);
    bit          redir;
    bit          e_req;
    bit          acc;
    bit          rt;
    int          old_out;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic [31:0] rp;
    logic [64:0] e_bus;
    @(negedge clk);
    br_stall          = s.br_stall;
    inst_sram_addr_ok = s.addr_ok;
    inst_sram_data_ok = s.data_ok;
    ds_allowin        = s.allowin;
    br_taken          = s.br_taken;
    wb_ex             = s.wb_ex;
    ertn_flush        = s.ertn;
    br_target         = s.br_target;
    ex_entry          = s.ex_entry;
    ertn_entry        = s.ertn_entry;
    inst_sram_rdata   = s.rdata;
    #1;
    redir  = s.wb_ex | s.ertn | s.br_taken;
    tgt    = s.wb_ex ? s.ex_entry : (s.ertn ? s.ertn_entry : s.br_target);
    e_addr = redir ? tgt : (m_pend ? m_pend_pc : m_seq);
    e_req  = !s.br_stall && (q_pc.size() < MAXO) && ((q_pc.size() + q_fq.size()) < DEPTH);
    e_bus  = '0;
    if (q_fq.size() > 0) e_bus = q_fq[0];
    s_req  = inst_sram_req;
    s_addr = inst_sram_addr;
    s_vld  = fs2ds_valid;
    s_bus  = fs2ds_bus;
    chk("req", s_req, e_req);
    chk("addr", s_addr, e_addr);
    chk("fs2ds_valid", s_vld, q_fq.size() > 0);
    chk("fs2ds_bus", s_bus, e_bus);
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_pf);
    chk("perf_discard", perf_discard_cnt, m_pd);
`endif
    acc     = e_req && s.addr_ok;
    rt      = s.data_ok && (q_pc.size() > 0);
    old_out = q_pc.size();
    if (s.allowin && q_fq.size() > 0) void'(q_fq.pop_front());
    if (rt) begin
      rp = q_pc.pop_front();
      if (redir || m_disc > 0) begin
        m_pd++;
        if (!redir) m_disc--;
      end else begin
        q_fq.push_back({rp[1:0] != 2'b00, s.rdata, rp});
      end
    end
    if (redir) begin
      q_fq.delete();
      m_disc = old_out - (rt ? 1 : 0);
    end
    if (acc) begin
      q_pc.push_back(e_addr);
      m_seq = e_addr + 32'd4;
      m_pf++;
    end
    if (redir && !acc) begin
      m_pend    = 1'b1;
      m_pend_pc = tgt;
    end else if (acc) begin
      m_pend = 1'b0;
    end
  endtask

  // Step with fixed handshakes until decode sees a valid head, bounded.
  task automatic wait_valid(input stim_t s, output logic [64:0] bus, output bit found);
    found = 1'b0;
    bus   = '0;
    for (int i = 0; i < 30 && !found; i++) begin
      s.rdata = $urandom;
      step(s);
      if (s_vld) begin
        found = 1'b1;
        bus   = s_bus;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t       s;
    logic [64:0] bus;
    bit          found;
    int          drained;
    logic [31:0] t;

    resetn = 1'b0;
    br_stall = 0; inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = '0;
    ds_allowin = 0; br_taken = 0; br_target = '0; wb_ex = 0; ex_entry = '0;
    ertn_flush = 0; ertn_entry = '0;

    // Sequential fetch, then a branch with two requests in flight and a non-empty FIFO.
    tbl[0]  = v(1, 0, 1, 0, 0,        1, B + 32'h000, 0, 0);
    tbl[1]  = v(1, 1, 1, 0, 0,        1, B + 32'h004, 0, 0);
    tbl[2]  = v(1, 1, 1, 0, 0,        1, B + 32'h008, 1, B + 32'h000);
    tbl[3]  = v(1, 1, 1, 0, 0,        1, B + 32'h00C, 1, B + 32'h004);
    tbl[4]  = v(1, 0, 0, 0, 0,        1, B + 32'h010, 1, B + 32'h008);
    tbl[5]  = v(0, 0, 0, 1, B + 'h100, 0, B + 32'h100, 1, B + 32'h008);
    tbl[6]  = v(1, 1, 1, 0, 0,        0, B + 32'h100, 0, 0);
    tbl[7]  = v(1, 1, 1, 0, 0,        1, B + 32'h100, 0, 0);
    tbl[8]  = v(1, 1, 1, 0, 0,        1, B + 32'h104, 0, 0);
    tbl[9]  = v(0, 1, 1, 0, 0,        1, B + 32'h108, 1, B + 32'h100);
    tbl[10] = v(0, 0, 1, 0, 0,        1, B + 32'h108, 1, B + 32'h104);
    tbl[11] = v(0, 0, 1, 0, 0,        1, B + 32'h108, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", inst_sram_req, 1'b0);
    chk("rst_valid", fs2ds_valid, 1'b0);
    chk("rst_bus", fs2ds_bus, 65'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].s);
      chk($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_vld", i), s_vld, tbl[i].vld);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i), s_bus[31:0], tbl[i].pc);
        chk($sformatf("tbl%0d_adef", i), s_bus[64], 1'b0);
      end
    end

    // Decode stalled: FIFO fills to DEPTH and requests stop, then drains in order.
    for (int i = 0; i < 8; i++) step(mk(1, 1, 0));
    chk("fill_req_off", s_req, 1'b0);
    chk("fill_valid", s_vld, 1'b1);
    drained = 0;
    for (int i = 0; i < 6; i++) begin
      step(mk(0, 0, 1));
      if (s_vld) drained++;
    end
    chk("fill_drained", drained, 4);

    // Exception and branch together, with a return landing in the redirect cycle.
    step(mk(1, 0, 1));
    step(mk(1, 0, 1));
    s = mk(1, 1, 1);
    s.wb_ex     = 1'b1;
    s.br_taken  = 1'b1;
    s.ex_entry  = 32'h1C00_8000;
    s.br_target = 32'h1C00_0100;
    step(s);
    chk("ex_addr", s_addr, 32'h1C00_8000);
    wait_valid(mk(1, 1, 1), bus, found);
    chk("ex_found", found, 1'b1);
    chk("ex_first_pc", bus[31:0], 32'h1C00_8000);
`ifdef FETCH_PERF_EN
    chk("perf_discard_redirects", perf_discard_cnt, 32'd4);
`endif
    for (int i = 0; i < 4; i++) step(mk(0, 1, 1));

    // Redirect while addr_ok is held low: target parked on the address until accepted.
    s = mk(0, 0, 1);
    s.ertn       = 1'b1;
    s.ertn_entry = 32'h1C00_2000;
    step(s);
    chk("pend_addr0", s_addr, 32'h1C00_2000);
    for (int i = 1; i <= 3; i++) begin
      step(mk(0, 0, 1));
      chk($sformatf("pend_addr%0d", i), s_addr, 32'h1C00_2000);
    end
    step(mk(1, 0, 1));
    chk("pend_acc_req", s_req, 1'b1);
    chk("pend_acc_addr", s_addr, 32'h1C00_2000);
    step(mk(0, 0, 1));
    chk("pend_resume", s_addr, 32'h1C00_2004);

    // Misaligned branch target is fetched and tagged with adef.
    s = mk(0, 0, 1);
    s.br_taken  = 1'b1;
    s.br_target = 32'h1C00_0102;
    step(s);
    wait_valid(mk(1, 1, 1), bus, found);
    chk("adef_found", found, 1'b1);
    chk("adef_pc", bus[31:0], 32'h1C00_0102);
    chk("adef_bit", bus[64], 1'b1);

    // Random traffic with occasional stalls, redirects and misaligned targets.
    for (int i = 0; i < 3000; i++) begin
      s = mk($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
      s.br_stall = ($urandom_range(0, 9) == 0);
      s.br_taken = ($urandom_range(0, 19) == 0);
      s.wb_ex    = ($urandom_range(0, 39) == 0);
      s.ertn     = ($urandom_range(0, 39) == 0);
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      s.br_target  = t;
      s.ex_entry   = t ^ 32'h0000_1000;
      s.ertn_entry = t ^ 32'h0000_2000;
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised successor to the single-entry IF stage. It sits between the pre-IF/IF logic and the decode stage. It keeps up to MAX_OUTSTANDING in-flight instruction-SRAM read requests and buffers returned instructions in a DEPTH-entry FIFO toward decode. Redirects (exception, ertn, branch) discard any number of stale in-flight responses using a counter, replacing the single discard flag.

Parameters:
DEPTH, 4, instruction FIFO entries toward decode (power of 2, ≥2)
MAX_OUTSTANDING, 2, max accepted-but-unreturned SRAM requests (1..DEPTH)
RESET_PC, 32'h1C00_0000, first fetch address after reset

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
inst_sram_req  out  1  fetch request valid
inst_sram_addr  out  32  fetch address (nextpc)
inst_sram_addr_ok  in  1  request accepted this cycle
inst_sram_data_ok  in  1  read data returned this cycle (in order)
inst_sram_rdata  in  32  returned instruction
ds_allowin  in  1  decode accepts
br_stall  in  1  branch unresolved, suppress new requests
br_taken  in  1  branch redirect pulse
br_target  in  32  branch target
wb_ex  in  1  exception redirect pulse
ex_entry  in  32  exception entry
ertn_flush  in  1  ertn redirect pulse
ertn_entry  in  32  ertn target
fs2ds_valid  out  1  FIFO head valid
fs2ds_bus  out  65  {adef, inst[31:0], pc[31:0]} of FIFO head

Behaviour:
- Reset (async assert, sync release): FIFO empty, outstanding=0, discard_cnt=0, no pending redirect, next fetch pc=RESET_PC. Outputs at reset: inst_sram_req=0, fs2ds_valid=0, fs2ds_bus=0.
- Redirect priority is wb_ex > ertn_flush > br_taken. The winning target is latched into a pending-redirect register, held until a request is accepted (addr_ok), then cleared.
- nextpc, in priority order: live redirect target; pending redirect target; last accepted pc+4 (wraps mod 2^32).
- inst_sram_req = resetn & ~br_stall & (outstanding < MAX_OUTSTANDING) & (outstanding + fifo_count < DEPTH). The credit check guarantees every return has a FIFO slot.
- inst_sram_req and inst_sram_addr stay stable until addr_ok. The only exception is a redirect, which changes addr to the new target in the same cycle.
- On accept (req & addr_ok): outstanding+1; the pc is pushed to an internal pc queue (MAX_OUTSTANDING entries).
- On data_ok: outstanding-1; the pc queue pops. If discard_cnt>0, the data is dropped and discard_cnt-1. Otherwise push {pc[1:0]!=0, rdata, pc} into the FIFO.
- On redirect cycle:
  - FIFO flushed; fs2ds_valid=0 the next cycle.
  - discard_cnt <= outstanding - data_ok (data returning this cycle is dropped).
  - The pc queue is marked stale by discard_cnt; no pc-queue flush is needed.
  - A request accepted in the same cycle carries the new target and is NOT discarded.
- Redirect while discard_cnt>0: discard_cnt reloads with the full current outstanding (old stale count is subsumed).
- FIFO pop when fs2ds_valid & ds_allowin. Simultaneous push and pop is allowed at full and at empty.
- An empty FIFO with a push and no pop makes the head valid the next cycle. Latency is 1 cycle from data_ok to fs2ds_valid; there is no combinational path from rdata to fs2ds_bus.
- Misaligned pc is still requested; the adef bit is carried with the entry.
- Counters are sized clog2(MAX_OUTSTANDING+1) and clog2(DEPTH+1); neither ever overflows or underflows. data_ok with outstanding=0 is illegal; the design ignores it and does not change state.

Optional Feature:
FETCH_PERF_EN:
- When defined, adds output ports perf_fetch_cnt[31:0] (accepted requests) and perf_discard_cnt[31:0] (dropped responses). Both are free-running, wrap-around, and reset to 0.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset, then SRAM with addr_ok=1 and data_ok 1 cycle later, ds_allowin=1. Fetch pcs are 1C000000, 1C000004, 1C000008. Each fs2ds_bus pc matches and adef=0. Outstanding never exceeds 2.
2. ds_allowin=0 with DEPTH=4. The FIFO fills to 4 and inst_sram_req drops once outstanding+count=4. Release ds_allowin: entries drain in order and no instruction is lost.
3. Two requests outstanding (pcs A, A+4), br_taken with target 1C000100, no data_ok that cycle. discard_cnt=2, the next two returns are dropped, the first delivered pc is 1C000100, and the FIFO is empty right after the redirect.
4. wb_ex and br_taken in the same cycle with ex_entry=1C008000. nextpc is 1C008000. A data_ok in that cycle is dropped and discard_cnt equals outstanding-1.
5. Redirect while addr_ok is held low for 3 cycles. The pending target is held on inst_sram_addr until accepted, then the sequential pc resumes at target+4.
6. br_target=1C000102. The delivered entry has adef=1 and pc=1C000102. With FETCH_PERF_EN defined, perf_discard_cnt equals the number of dropped returns across scenarios 3-4.
